// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder that time-shares one decimal digit cell,
// resolving one digit per clock from LSD to MSD.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  c_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  c_out,
  output logic                  invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d, c_out_q, c_out_d, invalid_q, invalid_d;

  logic [3:0]       cell_a, cell_b, cell_sum;
  logic [4:0]       cell_raw;
  logic             cell_cout;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    has_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
    end
  endfunction

  // Shared dec_adder digit cell: binary add, then +6 correction past 9.
  always_comb begin
    cell_a   = a_q[{idx_q, 2'b00} +: 4];
    cell_b   = b_q[{idx_q, 2'b00} +: 4];
    cell_raw = {1'b0, cell_a} + {1'b0, cell_b} + {4'b0000, carry_q};
    if (cell_raw > 5'd9) begin
      cell_sum  = cell_raw[3:0] + 4'd6;
      cell_cout = 1'b1;
    end else begin
      cell_sum  = cell_raw[3:0];
      cell_cout = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    c_out_d   = c_out_q;
    invalid_d = invalid_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          carry_d   = c_in;
          idx_d     = '0;
          sum_d     = '0;
          invalid_d = has_bad_digit(a) | has_bad_digit(b);
          state_d   = S_RUN;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = cell_sum;
        carry_d = cell_cout;
        if (idx_q == LAST_IDX) begin
          c_out_d = cell_cout;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      c_out_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      c_out_q   <= c_out_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign sum     = sum_q;
  assign c_out   = c_out_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4): expected results come from
// an integer decimal model pushed to a scoreboard queue at each start.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n, start, c_in;
  logic [W-1:0] a, b;
  logic         busy, done, c_out, invalid;
  logic [W-1:0] sum;

  typedef struct {
    string        tag;
    logic [W-1:0] sum;
    logic         c_out;
    logic         invalid;
    logic         chk_sum;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   failed    = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic bad_bcd(input logic [W-1:0] v);
    bad_bcd = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad_bcd = 1'b1;
  endfunction

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input string tag, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic ci);
    exp_t e;
    int   total;
    e.tag     = tag;
    e.invalid = bad_bcd(av) | bad_bcd(bv);
    e.chk_sum = !e.invalid;
    total     = bcd_to_int(av) + bcd_to_int(bv) + int'(ci);
    e.sum     = e.invalid ? '0 : int_to_bcd(total % 10000);
    e.c_out   = e.invalid ? 1'b0 : (total >= 10000);
    return e;
  endfunction

  // Drive a request and let it be sampled; optionally keep start high.
  task automatic launch(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic hold);
    a = av; b = bv; c_in = ci; start = 1'b1;
    exp_q.push_back(model(tag, av, bv, ci));
    step();
    if (!hold) start = 1'b0;
  endtask

  // Count busy cycles until done (bounded), then pop and compare the result.
  task automatic wait_done(input int exp_busy);
    int   n = 0;
    int   busy_cnt = 0;
    exp_t e;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      step();
      n++;
    end
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, "_done"},    done,     1);
    check({e.tag, "_busy_n"},  busy_cnt, exp_busy);
    check({e.tag, "_busy_lo"}, busy,     0);
    check({e.tag, "_invalid"}, invalid,  e.invalid);
    if (e.chk_sum) begin
      check({e.tag, "_sum"},   sum,      e.sum);
      check({e.tag, "_c_out"}, c_out,    e.c_out);
    end
  endtask

  // After the done cycle: pulse must have dropped and the result must hold.
  task automatic after_done(input string tag);
    logic [W-1:0] s;
    logic         co;
    s = sum; co = c_out;
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"},  busy, 0);
    check({tag, "_sum_hold"},   sum,  s);
    check({tag, "_cout_hold"},  c_out, co);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; c_in = 1'b0; a = '0; b = '0;
    step(); step();
    check("rst_busy",    busy,    0);
    check("rst_done",    done,    0);
    check("rst_sum",     sum,     0);
    check("rst_c_out",   c_out,   0);
    check("rst_invalid", invalid, 0);
    rst_n = 1'b1;
    step();

    launch("t1", 16'h1234, 16'h5678, 1'b0, 1'b0);
    check("t1_busy_after_start", busy, 1);
    wait_done(4);
    after_done("t1");

    launch("t2", 16'h9999, 16'h0001, 1'b0, 1'b0);
    wait_done(4);
    after_done("t2");

    launch("t3a", 16'h0000, 16'h0000, 1'b1, 1'b0);
    wait_done(4);
    after_done("t3a");

    launch("t3b", 16'h9999, 16'h9999, 1'b1, 1'b0);
    wait_done(4);
    after_done("t3b");

    launch("t4a", 16'h00A0, 16'h0000, 1'b0, 1'b0);
    check("t4a_sum_cleared", sum, 0);
    wait_done(4);
    after_done("t4a");

    launch("t4b", 16'h0042, 16'h0358, 1'b0, 1'b0);
    wait_done(4);

    step();
    // Re-pulse start with different operands mid-RUN: must be ignored.
    launch("t5a", 16'h0100, 16'h0200, 1'b0, 1'b0);
    step();
    a = 16'h9999; b = 16'h9999; c_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(2);
    after_done("t5a");

    // start held through DONE: second addition follows without an IDLE cycle.
    launch("t5b1", 16'h4321, 16'h1111, 1'b0, 1'b1);
    wait_done(4);
    a = 16'h9999; b = 16'h9999; c_in = 1'b1;
    exp_q.push_back(model("t5b2", a, b, c_in));
    step();
    start = 1'b0;
    check("t5b_no_idle", busy, 1);
    wait_done(4);
    after_done("t5b2");

    // Reset during the second RUN cycle.
    launch("t6", 16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    void'(exp_q.pop_back());
    check("t6_rst_busy",  busy,  0);
    check("t6_rst_done",  done,  0);
    check("t6_rst_sum",   sum,   0);
    check("t6_rst_c_out", c_out, 0);
    rst_n = 1'b1;
    step();
    launch("t6b", 16'h0987, 16'h0654, 1'b0, 1'b0);
    wait_done(4);

    if (exp_q.size() != 0) begin
      failed++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
